unidade_flags: RTL and testbench
================================

Name: unidade_flags

Overview:
- Producer side of the NZCV condition-flag interface: computes N, Z, C and V from ALU results and holds the architectural flags register.
- The condition validation unit consumes its FlagsNZCV output and returns Inibe.
- Flag commit is a two-stage pipeline (capture, then compute/commit). Adds an MSR-style direct write and a one-deep exception save/restore shadow.
- Sits beside the ALU in the EX stage.

Parameters:
- W, 32, datapath width of OperandoA, OperandoB and Resultado.
- FLAGS_RESET, 4'b0000, reset value of FlagsNZCV and FlagsSalvas.

Ports:
- Clock  input  1  single clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Valido  input  1  an instruction is present in EX this cycle.
- SetFlags  input  1  S bit of the EX instruction.
- Inibe  input  1  from the condition validation unit; 1 = instruction annulled.
- OpClasse  input  2  00 ADD, 01 SUB (A-B), 10 logical, 11 MOV/shift.
- OperandoA  input  W  ALU operand A.
- OperandoB  input  W  ALU operand B (post-shifter).
- Resultado  input  W  ALU result.
- CarryShift  input  1  shifter carry-out, used for classes 10/11.
- EscreveFlags  input  1  direct flag write (MSR).
- FlagsIn  input  4  value for EscreveFlags, bit order {N,Z,C,V}.
- SalvaFlags  input  1  exception entry: copy flags to shadow.
- RestauraFlags  input  1  exception return: copy shadow to flags.
- FlagsNZCV  output  4  architectural flags {N,Z,C,V}, registered.
- FlagsPendente  output  1  a flag-setting instruction is in flight (uncommitted).
- FlagsSalvas  output  4  shadow register contents.

Behaviour:
- Reset low, asynchronously: FlagsNZCV = FlagsSalvas = FLAGS_RESET, FlagsPendente = 0, stage register cleared. A flag update in flight at reset is discarded.
- Stage 1 (capture):
  - At an edge where Valido & SetFlags & ~Inibe, register OpClasse, A, B, Resultado and CarryShift, and set the stage-valid bit.
  - Otherwise stage-valid clears.
  - FlagsPendente = stage-valid.
- Stage 2 (commit): at the next edge, if stage-valid, FlagsNZCV takes the computed NZCV. Latency is exactly one cycle from capture edge to commit edge. Back-to-back flag-setting instructions are accepted every cycle with no stall.
- Flag computation:
  - All classes: N = R[W-1]; Z = (R == 0).
  - ADD: C = bit W of the (W+1)-bit sum A+B; V = (A[W-1]==B[W-1]) & (R[W-1]!=A[W-1]).
  - SUB: C = ~borrow = (A >= B unsigned); V = (A[W-1]!=B[W-1]) & (R[W-1]!=A[W-1]).
  - Logical/MOV: C = CarryShift; V keeps its post-commit-edge prior value (held, not recomputed).
- Next-value priority for FlagsNZCV at one edge, highest first:
  1. Reset.
  2. RestauraFlags → FlagsSalvas.
  3. EscreveFlags → FlagsIn.
  4. Staged commit.
  5. Hold.
  - MSR beats the staged commit because the MSR is the younger instruction.
- SalvaFlags: FlagsSalvas takes the value FlagsNZCV would hold after the in-flight commit (staged result if stage-valid, else current flags), so a pending update is never lost on exception entry.
- SalvaFlags & RestauraFlags together: swap. The flags take the old shadow; the shadow takes the effective value defined above.
- RestauraFlags or EscreveFlags also clears stage-valid in the same edge; the superseded update is dropped.
- Inibe=1 or SetFlags=0: no capture and no change, even if Valido=1.
- Valido=0 ignores SetFlags and Inibe.
- No combinational path from any input to FlagsNZCV. FlagsPendente is the only hazard indication; downstream stalls on it.

Decomposition:
- Shared package:
  - OpClasse codes OP_ADD/OP_SUB/OP_LOG/OP_MOV.
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FLAGS_RESET.
  - These are also used by the condition validation unit.
- One natural combinational sub-module, calculo_nzcv: (OpClasse, A, B, R, CarryShift, Vprev) → NZCV. The top level holds the pipeline registers, priority mux and shadow.

Test Plan:
- Reset low mid-capture (stage-valid=1) → FlagsNZCV=0000 and FlagsPendente=0 immediately; no commit after release.
- ADD A=32'h7FFFFFFF, B=1, R=32'h80000000, S=1, Inibe=0 → FlagsPendente=1 for one cycle, then FlagsNZCV=1001.
- SUB A=5, B=5, R=0 → 0110; then SUB A=0, B=1, R=32'hFFFFFFFF → 1000 on the next commit edge (back-to-back, no stall).
- Flags=0001, logical op R=0, CarryShift=1 → 0111 (V held). Same stimulus with Inibe=1 → flags unchanged, FlagsPendente=0.
- ADD captured, then EscreveFlags with FlagsIn=1010 on the commit edge → FlagsNZCV=1010 and the ADD result is discarded.
- Flags=0100, staged ADD yielding 0010, SalvaFlags on the commit edge → FlagsSalvas=0010. Later SalvaFlags & RestauraFlags together with flags=1000 → FlagsNZCV=0010, FlagsSalvas=1000.

Source files
------------

// File: rtl/unidade_flags_pkg.sv
// Shared NZCV definitions: ALU class codes, flag bit positions and reset value.
// The condition validation unit uses the same package.
package unidade_flags_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_LOG = 2'b10;
    localparam logic [1:0] OP_MOV = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] FLAGS_RESET = 4'b0000;

endpackage

// File: rtl/unidade_flags_calculo_nzcv.sv
// Combinational NZCV computation from a captured ALU operation.
// V is passed through from v_prev for the logical and MOV/shift classes.
module calculo_nzcv
    import unidade_flags_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [1:0]   op_classe,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] r,
    input  logic         carry_shift,
    input  logic         v_prev,
    output logic [3:0]   nzcv
);

    logic [W-1:0] soma;
    logic         carry_add;

    // The sum wraps exactly when the unsigned result is smaller than an operand.
    assign soma      = a + b;
    assign carry_add = (soma < a);

    always_comb begin
        nzcv         = '0;
        nzcv[FLAG_N] = r[W-1];
        nzcv[FLAG_Z] = (r == '0);
        case (op_classe)
            OP_ADD: begin
                nzcv[FLAG_C] = carry_add;
                nzcv[FLAG_V] = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            OP_SUB: begin
                nzcv[FLAG_C] = (a >= b);
                nzcv[FLAG_V] = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            default: begin
                nzcv[FLAG_C] = carry_shift;
                nzcv[FLAG_V] = v_prev;
            end
        endcase
    end

endmodule

// File: rtl/unidade_flags.sv
// NZCV flags producer: two-stage capture/commit pipeline, MSR-style direct
// write and a one-deep exception shadow register.
module unidade_flags #(
    parameter int         W           = 32,
    parameter logic [3:0] FLAGS_RESET = unidade_flags_pkg::FLAGS_RESET
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Valido,
    input  logic         SetFlags,
    input  logic         Inibe,
    input  logic [1:0]   OpClasse,
    input  logic [W-1:0] OperandoA,
    input  logic [W-1:0] OperandoB,
    input  logic [W-1:0] Resultado,
    input  logic         CarryShift,
    input  logic         EscreveFlags,
    input  logic [3:0]   FlagsIn,
    input  logic         SalvaFlags,
    input  logic         RestauraFlags,
    output logic [3:0]   FlagsNZCV,
    output logic         FlagsPendente,
    output logic [3:0]   FlagsSalvas
);

    import unidade_flags_pkg::*;

    logic         st_valid;
    logic [1:0]   st_op;
    logic [W-1:0] st_a;
    logic [W-1:0] st_b;
    logic [W-1:0] st_r;
    logic         st_cs;

    logic         captura;
    logic         descarta;
    logic [3:0]   flags_calc;
    logic [3:0]   flags_eff;
    logic [3:0]   flags_next;

    calculo_nzcv #(.W(W)) u_calc (
        .op_classe   (st_op),
        .a           (st_a),
        .b           (st_b),
        .r           (st_r),
        .carry_shift (st_cs),
        .v_prev      (FlagsNZCV[FLAG_V]),
        .nzcv        (flags_calc)
    );

    assign captura  = Valido && SetFlags && !Inibe;
    // A direct write or restore supersedes whatever is staged.
    assign descarta = RestauraFlags || EscreveFlags;

    // Value the flags hold once the in-flight update lands; saved on exception entry.
    assign flags_eff = st_valid ? flags_calc : FlagsNZCV;

    always_comb begin
        flags_next = FlagsNZCV;
        if (RestauraFlags)
            flags_next = FlagsSalvas;
        else if (EscreveFlags)
            flags_next = FlagsIn;
        else if (st_valid)
            flags_next = flags_calc;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            st_valid <= 1'b0;
            st_op    <= '0;
            st_a     <= '0;
            st_b     <= '0;
            st_r     <= '0;
            st_cs    <= 1'b0;
        end else begin
            st_valid <= captura && !descarta;
            if (captura) begin
                st_op <= OpClasse;
                st_a  <= OperandoA;
                st_b  <= OperandoB;
                st_r  <= Resultado;
                st_cs <= CarryShift;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            FlagsNZCV   <= FLAGS_RESET;
            FlagsSalvas <= FLAGS_RESET;
        end else begin
            FlagsNZCV <= flags_next;
            if (SalvaFlags)
                FlagsSalvas <= flags_eff;
        end
    end

    assign FlagsPendente = st_valid;

endmodule

// File: tb/tb_unidade_flags.sv
// Self-checking bench for unidade_flags: directed scenarios plus random
// traffic compared each cycle against a transaction-level reference model.
module tb_unidade_flags;

    localparam int W = 32;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         Valido, SetFlags, Inibe;
    logic [1:0]   OpClasse;
    logic [W-1:0] OperandoA, OperandoB, Resultado;
    logic         CarryShift;
    logic         EscreveFlags;
    logic [3:0]   FlagsIn;
    logic         SalvaFlags, RestauraFlags;
    logic [3:0]   FlagsNZCV;
    logic         FlagsPendente;
    logic [3:0]   FlagsSalvas;

    unidade_flags #(.W(W), .FLAGS_RESET(4'b0000)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .Valido        (Valido),
        .SetFlags      (SetFlags),
        .Inibe         (Inibe),
        .OpClasse      (OpClasse),
        .OperandoA     (OperandoA),
        .OperandoB     (OperandoB),
        .Resultado     (Resultado),
        .CarryShift    (CarryShift),
        .EscreveFlags  (EscreveFlags),
        .FlagsIn       (FlagsIn),
        .SalvaFlags    (SalvaFlags),
        .RestauraFlags (RestauraFlags),
        .FlagsNZCV     (FlagsNZCV),
        .FlagsPendente (FlagsPendente),
        .FlagsSalvas   (FlagsSalvas)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: architectural flags, shadow, and a queue of at most one
    // pending flag-setting instruction.
    typedef struct {
        logic [1:0]   cls;
        logic [W-1:0] a, b, r;
        logic         cs;
    } instr_t;

    logic [3:0] m_flags, m_shadow;
    instr_t     m_pend[$];

    function automatic logic [3:0] ref_nzcv(instr_t i, logic [3:0] cur);
        logic n, z, c, v;
        longint unsigned ua, ub;
        ua = longint'(i.a);
        ub = longint'(i.b);
        n = i.r[W-1];
        z = (i.r == 0);
        case (i.cls)
            2'b00: begin
                c = (ua + ub) >= (64'd1 << W);
                v = (i.a[W-1] == i.b[W-1]) && (i.r[W-1] != i.a[W-1]);
            end
            2'b01: begin
                c = (ua >= ub);
                v = (i.a[W-1] != i.b[W-1]) && (i.r[W-1] != i.a[W-1]);
            end
            default: begin
                c = i.cs;
                v = cur[0];
            end
        endcase
        return {n, z, c, v};
    endfunction

    task automatic idle();
        Valido = 0; SetFlags = 0; Inibe = 0; OpClasse = 0;
        OperandoA = 0; OperandoB = 0; Resultado = 0; CarryShift = 0;
        EscreveFlags = 0; FlagsIn = 0; SalvaFlags = 0; RestauraFlags = 0;
    endtask

    task automatic set_op(input logic [1:0] cls, input logic [W-1:0] a, b, r, input logic cs);
        Valido = 1; SetFlags = 1; OpClasse = cls;
        OperandoA = a; OperandoB = b; Resultado = r; CarryShift = cs;
    endtask

    // One clock: advance the model with the current inputs, clock the DUT, compare.
    task automatic cyc(input string tag);
        logic [3:0] eff, nf;
        instr_t     ni;
        eff = (m_pend.size() != 0) ? ref_nzcv(m_pend[0], m_flags) : m_flags;
        if (RestauraFlags)      nf = m_shadow;
        else if (EscreveFlags)  nf = FlagsIn;
        else                    nf = eff;
        if (SalvaFlags) m_shadow = eff;
        m_flags = nf;
        m_pend.delete();
        if (Valido && SetFlags && !Inibe && !EscreveFlags && !RestauraFlags) begin
            ni.cls = OpClasse; ni.a = OperandoA; ni.b = OperandoB;
            ni.r = Resultado; ni.cs = CarryShift;
            m_pend.push_back(ni);
        end
        @(posedge Clock);
        #1;
        chk({tag, ".flags"},  32'(FlagsNZCV),     32'(m_flags));
        chk({tag, ".shadow"}, 32'(FlagsSalvas),   32'(m_shadow));
        chk({tag, ".pend"},   32'(FlagsPendente), 32'(m_pend.size()));
        idle();
    endtask

    task automatic model_reset();
        m_flags = 4'b0000;
        m_shadow = 4'b0000;
        m_pend.delete();
    endtask

    initial begin
        idle();
        model_reset();
        Reset = 0;
        #12;
        chk("rst.flags",  32'(FlagsNZCV), 32'h0);
        chk("rst.shadow", 32'(FlagsSalvas), 32'h0);
        chk("rst.pend",   32'(FlagsPendente), 32'h0);
        @(negedge Clock);
        Reset = 1;

        // Reset asserted while an update is staged: dropped, nothing commits after release.
        set_op(2'b00, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0);
        cyc("midcap");
        chk("midcap.pend_set", 32'(FlagsPendente), 32'h1);
        #2 Reset = 0;
        #1;
        model_reset();
        chk("midrst.flags", 32'(FlagsNZCV), 32'h0);
        chk("midrst.pend",  32'(FlagsPendente), 32'h0);
        @(negedge Clock);
        Reset = 1;
        cyc("afterrst");
        chk("afterrst.flags", 32'(FlagsNZCV), 32'h0);

        // ADD signed overflow.
        set_op(2'b00, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0);
        cyc("add.cap");
        chk("add.pend", 32'(FlagsPendente), 32'h1);
        cyc("add.com");
        chk("add.nzcv", 32'(FlagsNZCV), 32'h9);
        chk("add.pend0", 32'(FlagsPendente), 32'h0);

        // Back-to-back SUBs.
        set_op(2'b01, 32'd5, 32'd5, 32'd0, 0);
        cyc("sub1.cap");
        set_op(2'b01, 32'd0, 32'd1, 32'hFFFFFFFF, 0);
        cyc("sub2.cap");
        chk("sub1.nzcv", 32'(FlagsNZCV), 32'h6);
        chk("sub2.pend", 32'(FlagsPendente), 32'h1);
        cyc("sub2.com");
        chk("sub2.nzcv", 32'(FlagsNZCV), 32'h8);

        // Logical op holds V; annulled copy changes nothing.
        EscreveFlags = 1; FlagsIn = 4'b0001;
        cyc("msr0001");
        set_op(2'b10, 32'h0, 32'h0, 32'h0, 1);
        cyc("log.cap");
        cyc("log.com");
        chk("log.nzcv", 32'(FlagsNZCV), 32'h7);
        set_op(2'b10, 32'h0, 32'h0, 32'h12345678, 0);
        Inibe = 1;
        cyc("inibe.cap");
        chk("inibe.pend", 32'(FlagsPendente), 32'h0);
        cyc("inibe.com");
        chk("inibe.nzcv", 32'(FlagsNZCV), 32'h7);

        // MSR on the commit edge beats the staged ADD.
        set_op(2'b00, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0);
        cyc("msr.cap");
        EscreveFlags = 1; FlagsIn = 4'b1010;
        cyc("msr.com");
        chk("msr.nzcv", 32'(FlagsNZCV), 32'hA);
        chk("msr.pend", 32'(FlagsPendente), 32'h0);
        cyc("msr.hold");
        chk("msr.hold", 32'(FlagsNZCV), 32'hA);

        // Save captures the pending result; then swap.
        EscreveFlags = 1; FlagsIn = 4'b0100;
        cyc("sv.msr");
        set_op(2'b00, 32'hFFFFFFFF, 32'h2, 32'h1, 0);
        cyc("sv.cap");
        SalvaFlags = 1;
        cyc("sv.com");
        chk("sv.shadow", 32'(FlagsSalvas), 32'h2);
        chk("sv.nzcv",   32'(FlagsNZCV),   32'h2);
        EscreveFlags = 1; FlagsIn = 4'b1000;
        cyc("swap.msr");
        SalvaFlags = 1; RestauraFlags = 1;
        cyc("swap");
        chk("swap.nzcv",   32'(FlagsNZCV),   32'h2);
        chk("swap.shadow", 32'(FlagsSalvas), 32'h8);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            logic [W-1:0] a, b, r;
            logic [1:0]   cls;
            int           sel;
            cls = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 3);
            a = (sel == 0) ? 32'h7FFFFFFF : (sel == 1) ? 32'h80000000 : $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            case (cls)
                2'b00:   r = a + b;
                2'b01:   r = a - b;
                default: r = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) r = $urandom;
            Valido = ($urandom_range(0, 3) != 0);
            set_op(cls, a, b, r, 1'($urandom));
            Valido   = ($urandom_range(0, 3) != 0);
            SetFlags = ($urandom_range(0, 3) != 0);
            Inibe    = ($urandom_range(0, 4) == 0);
            EscreveFlags  = ($urandom_range(0, 9) == 0);
            FlagsIn       = 4'($urandom);
            SalvaFlags    = ($urandom_range(0, 7) == 0);
            RestauraFlags = ($urandom_range(0, 9) == 0);
            cyc("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
